// File: rtl/i_ap_pkg.sv
// Shared definitions for the approximate accumulator: parameter legality,
// segment count and FSM state encoding.
package i_ap_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_FIRST = 1'b0;
   localparam state_t ST_ACC   = 1'b1;

   // W must hold the exact low window plus a whole number of SEG-bit segments.
   function automatic bit ap_legal(input int unsigned w, input int unsigned seg,
                                   input int unsigned look);
      if (seg == 0) return 1'b0;
      if (w < seg + look) return 1'b0;
      return ((w - seg - look) % seg) == 0;
   endfunction

   // Number of segments including the exact low window.
   function automatic int unsigned ap_nseg(input int unsigned w, input int unsigned seg,
                                           input int unsigned look);
      if (seg == 0 || w < seg + look) return 1;
      return 1 + (w - seg - look) / seg;
   endfunction

endpackage

// File: rtl/i_ap_adder_p.sv
// Segmented carry-lookahead-truncated adder: exact low window, then
// independent upper segments that speculate carry from LOOK bits below.
module i_ap_adder_p
   import i_ap_pkg::*;
#(
   parameter int unsigned W    = 16,
   parameter int unsigned SEG  = 2,
   parameter int unsigned LOOK = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   localparam int unsigned SL   = SEG + LOOK;
   localparam int unsigned NSEG = ap_nseg(W, SEG, LOOK);

   generate
      if (!ap_legal(W, SEG, LOOK)) begin : g_illegal
         $error("i_ap_adder_p: (W-SEG-LOOK) must be a non-negative multiple of SEG");
      end
   endgenerate

   logic [SL:0] lo_sum;

   assign lo_sum       = {1'b0, a[SL-1:0]} + {1'b0, b[SL-1:0]};
   assign sum[SL-1:0]  = SL'(lo_sum);

   generate
      if (NSEG == 1) begin : g_one
         assign ovf = lo_sum[SL];
      end

      // Each window starts LOOK bits below its segment; no carry-in, keep top SEG bits.
      for (genvar k = 1; k < NSEG; k++) begin : g_seg
         logic [SL:0] ws;
         assign ws = {1'b0, a[k*SEG +: SL]} + {1'b0, b[k*SEG +: SL]};
         assign sum[SL + (k-1)*SEG +: SEG] = SEG'(ws >> LOOK);
         if (k == NSEG - 1) begin : g_top
            assign ovf = ws[SL];
         end
      end
   endgenerate

endmodule

// File: rtl/i_ap_accum.sv
// Streaming approximate vector accumulator with valid/ready framing.
// Define AP_SAT_EN to clamp the accumulator to all ones on overflow.
module i_ap_accum
   import i_ap_pkg::*;
#(
   parameter int unsigned W    = 16,
   parameter int unsigned SEG  = 2,
   parameter int unsigned LOOK = 2,
   parameter int unsigned CW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] out_count,
   output logic          out_ovf
);

   state_t        state, state_n;
   logic [W-1:0]  acc, acc_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          ovf, ovf_n;
   logic          out_valid_n;
   logic [W-1:0]  out_data_n;
   logic [CW-1:0] out_count_n;
   logic          out_ovf_n;

   logic [W-1:0]  add_sum;
   logic          add_ovf;
   logic          take;

   i_ap_adder_p #(
      .W    (W),
      .SEG  (SEG),
      .LOOK (LOOK)
   ) u_adder (
      .a   (acc),
      .b   (in_data),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   assign in_ready = !out_valid || out_ready;
   assign take     = in_valid && in_ready;

   // Next-state: beat accumulation, result hand-off and emit.
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      cnt_n       = cnt;
      ovf_n       = ovf;
      out_valid_n = out_valid;
      out_data_n  = out_data;
      out_count_n = out_count;
      out_ovf_n   = out_ovf;

      if (out_valid && out_ready) out_valid_n = 1'b0;

      if (take) begin
         if (state == ST_FIRST) begin
            acc_n = in_data;
            cnt_n = CW'(1);
            ovf_n = 1'b0;
         end else begin
`ifdef AP_SAT_EN
            acc_n = add_ovf ? {W{1'b1}} : add_sum;
`else
            acc_n = add_sum;
`endif
            cnt_n = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
            ovf_n = ovf | add_ovf;
         end

         if (in_last) begin
            state_n     = ST_FIRST;
            out_valid_n = 1'b1;
            out_data_n  = acc_n;
            out_count_n = cnt_n;
            out_ovf_n   = ovf_n;
         end else begin
            state_n = ST_ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FIRST;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
         ovf       <= ovf_n;
         out_valid <= out_valid_n;
         out_data  <= out_data_n;
         out_count <= out_count_n;
         out_ovf   <= out_ovf_n;
      end
   end

endmodule

// File: tb/tb_i_ap_accum.sv
// Directed scoreboard bench for i_ap_accum (default W=16, SEG=2, LOOK=2, CW=8).
// Honours AP_SAT_EN for the expected overflow result.
module tb_i_ap_accum;

   typedef struct packed {
      logic [15:0] data;
      logic [7:0]  count;
      logic        ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [7:0]  out_count;
   logic        out_ovf;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t sb[$];

   i_ap_accum #(.W(16), .SEG(2), .LOOK(2), .CW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every result handed off downstream is popped and compared.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'(out_data), 32'hDEAD);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("out_data",  32'(out_data),  32'(e.data));
            check("out_count", 32'(out_count), 32'(e.count));
            check("out_ovf",   32'(out_ovf),   32'(e.ovf));
         end
      end
   end

   // Present one beat and hold it until accepted, bounded.
   task automatic send(input logic [15:0] d, input logic last);
      bit ok;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_res(input logic [15:0] d, input logic [7:0] c, input logic o);
      res_t e;
      e.data  = d;
      e.count = c;
      e.ovf   = o;
      sb.push_back(e);
   endtask

   initial begin
      logic [15:0] ovf_exp;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_out_ovf",   32'(out_ovf),   32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1;

      // Carry-free vector; out_valid one cycle after the last beat.
      expect_res(16'h1235, 8'd2, 1'b0);
      send(16'h1234, 1'b0);
      check("valid_before_last", 32'(out_valid), 32'd0);
      send(16'h0001, 1'b1);
      check("valid_after_last", 32'(out_valid), 32'd1);

      // Carry caught by the lookahead window.
      expect_res(16'h0010, 8'd2, 1'b0);
      send(16'h0008, 1'b0);
      send(16'h0008, 1'b1);

      // Speculation miss: exact sum 0x0100 is lost.
      expect_res(16'h0000, 8'd2, 1'b0);
      send(16'h00F0, 1'b0);
      send(16'h0010, 1'b1);

      // Top-segment overflow.
`ifdef AP_SAT_EN
      ovf_exp = 16'hFFFF;
`else
      ovf_exp = 16'h0000;
`endif
      expect_res(ovf_exp, 8'd2, 1'b1);
      send(16'hF000, 1'b0);
      send(16'h1000, 1'b1);

      // Single-beat vector and a five-beat vector.
      expect_res(16'hABCD, 8'd1, 1'b0);
      send(16'hABCD, 1'b1);
      expect_res(16'h000F, 8'd5, 1'b0);
      for (int i = 1; i <= 5; i++) send(16'(i), (i == 5));

      // Backpressure: pending result holds and input stalls.
      @(posedge clk); #1;
      out_ready = 1'b0;
      expect_res(16'h0007, 8'd2, 1'b0);
      send(16'h0003, 1'b0);
      send(16'h0004, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h7777;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data",  32'(out_data),  32'h0007);
         check("bp_out_count", 32'(out_count), 32'd2);
         @(posedge clk); #1;
      end
      // Take the result while a new single-beat vector is accepted.
      expect_res(16'h0042, 8'd1, 1'b0);
      in_data   = 16'h0042;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("turn_out_valid", 32'(out_valid), 32'd1);
      check("turn_out_data",  32'(out_data),  32'h0042);
      check("turn_out_count", 32'(out_count), 32'd1);
      @(posedge clk); #1;
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Reset mid-vector discards the partial sum.
      send(16'h0100, 1'b0);
      send(16'h0100, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      expect_res(16'h0005, 8'd1, 1'b0);
      send(16'h0005, 1'b1);

      for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i_ap_accum.md
# i_ap_accum

Parametrised streaming approximate accumulator for the RBM datapath. It sums a vector of unsigned operands, one per accepted beat, with a segmented carry-lookahead-truncated adder. Width, segment size and lookahead depth are configurable. The block adds valid/ready flow control, vector framing, beat counting and overflow reporting, and registers each vector's result for the downstream neuron stage.

## Interface
Parameters:
- W, 16: operand/accumulator width.
- SEG, 2: result bits produced per upper segment.
- LOOK, 2: lookahead bits below each upper segment (carry speculation window).
- CW, 8: beat-counter width; vectors are at most 2^CW−1 beats.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  W  unsigned operand.
- in_last  in  1  final beat of current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  accumulated approximate sum.
- out_count  out  CW  beats in the vector.
- out_ovf  out  1  sticky overflow seen during the vector.

## Operation
Approximate add ap(a,b):
- Low window is exact: bits [SEG+LOOK−1:0] = (a+b) over those bits, carry dropped.
- Segment k≥1 covers result bits [SEG+LOOK+(k−1)·SEG +: SEG]. It is computed as the sum of the (SEG+LOOK)-bit windows of a and b that start LOOK bits below the segment. It takes no carry-in, and only the top SEG bits of the window sum are kept.
- Constraint: (W−SEG−LOOK) mod SEG = 0. Elaboration fails otherwise.
- Overflow: bit SEG+LOOK of the top segment's window sum.

Accumulation:
- A beat is accepted when in_valid && in_ready.
- FSM state FIRST, on an accepted beat: acc ← in_data, cnt ← 1, ovf ← 0. Go to ACC, or emit the result if in_last.
- FSM state ACC, on an accepted beat: acc ← ap(acc, in_data), cnt ← cnt+1, ovf ← ovf | overflow(acc, in_data). On in_last, emit and return to FIRST.
- Emit: out_data/out_count/out_ovf are loaded from the final values, including the last beat's contribution, and out_valid ← 1.
- in_ready = !out_valid || out_ready. Beats stall only while a result is pending and not taken.
- cnt saturates at 2^CW−1 and does not wrap. The bench never exceeds this limit.

## Timing
- Reset: out_valid=0, out_data=0, out_count=0, out_ovf=0, FSM=FIRST, acc=0, cnt=0, ovf=0. in_ready=1 the cycle after reset.
- Single-cycle accumulation; no internal pipeline.
- If the last beat is accepted in cycle t, out_valid is high in t+1.
- A single-beat vector gives out_data=in_data, out_count=1.
- out_valid holds its value until out_valid && out_ready. out_data/count/ovf stay stable while out_valid=1 and out_ready=0.
- Result taken and a new last beat accepted in the same cycle: out_valid stays 1 and the outputs update to the new vector in the next cycle.
- Result taken with no new last beat: out_valid → 0 next cycle.
- rst mid-vector discards the partial sum and any pending result.

## Configuration
- AP_SAT_EN defined: when the overflow bit is set on an accumulate, acc ← all ones for that beat. A saturated acc still takes later beats via ap().
- AP_SAT_EN undefined: the top segment wraps and acc keeps the truncated approximate sum.
- out_ovf behaves the same in both builds.

## Structure
- Shared package i_ap_pkg holds:
  - the legality check function for W/SEG/LOOK;
  - the segment-count constant function NSEG = 1 + (W−SEG−LOOK)/SEG;
  - the FSM state typedef (FIRST, ACC).
- One combinational sub-module, i_ap_adder_p (params W, SEG, LOOK; outputs sum and ovf), built with a generate loop over segments. i_ap_accum instantiates it once on (acc, in_data).

## Test plan
All with defaults W=16, SEG=2, LOOK=2.
- Carry-free vector 0x1234, 0x0001 (last) → out_data=0x1235, out_count=2, out_ovf=0, out_valid one cycle after last.
- Carry caught by the window: 0x0008, 0x0008 → 0x0010.
- Speculation miss: 0x00F0, 0x0010 → 0x0000 (exact sum is 0x0100); confirms approximate carry loss.
- Overflow: 0xF000, 0x1000 → out_ovf=1. Result is 0x0000 without AP_SAT_EN, 0xFFFF with it.
- Backpressure: hold out_ready=0 after a result and drive 3 beats. in_ready stays 0 and the outputs are unchanged. Then raise out_ready together with a new single-beat vector 0x0042 → next cycle out_data=0x0042, out_count=1, out_valid still 1.
- Reset mid-vector after beats 0x0100, 0x0100, then the vector 0x0005 (last) → out_data=0x0005, out_count=1.
